serial_mag_comp: RTL and testbench
==================================

Name: serial_mag_comp

Overview:
- Multi-cycle magnitude comparator for unsigned WIDTH-bit operands.
- Evaluates one bit per clock, MSB first, using the same per-bit rule as the team's 1-bit gate comparator: lt = ~a&b, gt = a&~b.
- Latches the first differing bit as the verdict; returns eq/gt/lt with a done pulse.
- Sits between reservoir state registers and threshold/winner-select logic, where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- EARLY_EXIT, 1, 1 = finish on the first differing bit; 0 = always scan all WIDTH bits (constant latency).
- CW, $clog2(WIDTH+1), width of the cycle-count output. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- busy  out  1  high while a comparison is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- eq  out  1  A==B; held until the next accepted start.
- gt  out  1  A>B; held until the next accepted start.
- lt  out  1  A<B; held until the next accepted start.
- cycles  out  CW  number of bit-steps used by the last comparison; held.

Behaviour:
- Clocking/reset: one clock. Reset is synchronous, active-low: on a clk edge with rst_n=0, all state clears.
- Reset values:
  - state=IDLE, busy=0, done=0.
  - eq=1, gt=0, lt=0 (two zero operands compare equal).
  - cycles=0, internal shift registers and bit index = 0.
- States:
  - IDLE: busy=0. On start=1, capture a and b into shift registers, set idx=WIDTH-1, clear the verdict, go to RUN. busy=1 from the next cycle.
  - RUN: each cycle, compare bit idx with the 1-bit rule.
    - If the bits differ and no verdict is latched yet, latch gt/lt.
    - If EARLY_EXIT=1 and a verdict was just latched, or idx==0, go to DONE.
    - Otherwise decrement idx.
    - cycles is incremented on every RUN cycle.
  - DONE: drive eq/gt/lt from the verdict; eq=1 only if no bit differed. Pulse done=1 for exactly this cycle; busy=0 this cycle; return to IDLE.
- Latency, start edge to done high:
  - EARLY_EXIT=1: k+1 cycles, where k = 1 + (WIDTH-1 - index of MSB-most differing bit). Equal operands take WIDTH+1.
  - EARLY_EXIT=0: always WIDTH+1.
- Outputs:
  - eq/gt/lt/cycles update only in DONE. Exactly one of eq/gt/lt is high at all times.
  - Outputs keep their previous values during RUN; they do not clear on start.
- Start handling:
  - start while busy=1 is ignored; it is not queued.
  - start in the DONE cycle is ignored.
  - start held high in IDLE launches back-to-back comparisons, one every latency+1 cycles.
- Operands: a/b may change after the capture cycle with no effect on the comparison in progress.
- Reset mid-RUN: abort immediately. Outputs return to their reset values and no done pulse is issued.
- Boundaries:
  - idx never wraps below 0.
  - A differing bit at idx=0 is latched on the same cycle RUN ends.
  - WIDTH=2 minimum.
- Comparison is unsigned only. Compare signed values by inverting the MSBs externally.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> eq=1, gt=0, lt=0, busy=0, done=0, cycles=0.
- WIDTH=8, EARLY_EXIT=1, a=0x80, b=0x7F, start pulse -> done 2 cycles after start, gt=1, cycles=1.
- WIDTH=8, EARLY_EXIT=1, a=0x12, b=0x13 -> done at +9, lt=1, cycles=8. Then a=b=0xA5 -> done at +9, eq=1, cycles=8.
- WIDTH=8, EARLY_EXIT=0, a=0xF0, b=0x0F -> done at +9, gt=1, cycles=8. Verdict stays gt even though later bits favour B.
- Robustness:
  - Pulse start again at +3 during RUN -> ignored; only one done pulse.
  - Change a/b at +1 -> result still matches the captured operands.
  - Assert rst_n=0 at +4 -> no done; outputs return to reset values.
- Random self-check: 1000 random (a,b) pairs per EARLY_EXIT value, start held high -> each result matches the golden model (a>b, a<b, a==b). Verify latency and cycles against the formulas above.

Source files
------------

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: bit-serial MSB-first unsigned magnitude comparator with latched verdict
module serial_mag_comp #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    cycles
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d, cyc_q, cyc_d;
  logic             vg_q, vg_d, vl_q, vl_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic             g, l, hit, fin;
  // the bit under test always sits at the MSB of the shift registers
  assign g   = sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
  assign l   = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];
  assign hit = (g | l) & ~(vg_q | vl_q);
  assign fin = ((EARLY_EXIT != 0) && hit) || (idx_q == '0);
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign eq     = eq_q;
  assign gt     = gt_q;
  assign lt     = lt_q;
  assign cycles = cyc_q;
  // state and datapath registers, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      vg_q    <= 1'b0;
      vl_q    <= 1'b0;
      eq_q    <= 1'b1;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      vg_q    <= vg_d;
      vl_q    <= vl_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end
  // next state: capture on start, one bit-step per RUN cycle, publish results on entry to DONE
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    vg_d    = vg_q;
    vl_d    = vl_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: if (start) begin
        sa_d    = a;
        sb_d    = b;
        idx_d   = IW'(WIDTH - 1);
        cnt_d   = '0;
        vg_d    = 1'b0;
        vl_d    = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        vg_d  = vg_q | (hit & g);
        vl_d  = vl_q | (hit & l);
        cnt_d = cnt_q + 1'b1;
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        if (fin) begin
          state_d = DONE;
          eq_d    = ~(vg_d | vl_d);
          gt_d    = vg_d;
          lt_d    = vl_d;
          cyc_d   = cnt_d;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: scoreboard bench for serial_mag_comp, one instance per EARLY_EXIT setting
module tb_serial_mag_comp;
  typedef struct {
    logic eq, gt, lt;
    int   cyc, lat, c0;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] busy, done, eq, gt, lt;
  logic [7:0] a [2];
  logic [7:0] b [2];
  logic [3:0] cy [2];
  int         cyc = 0, checks = 0, errors = 0;
  exp_t       q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .done(done[0]), .eq(eq[0]), .gt(gt[0]), .lt(lt[0]), .cycles(cy[0]));
  serial_mag_comp #(.WIDTH(8), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .done(done[1]), .eq(eq[1]), .gt(gt[1]), .lt(lt[1]), .cycles(cy[1]));

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // reference: plain unsigned compare; step count from the MSB-most differing bit position
  task automatic push(int j, logic [7:0] x, logic [7:0] y, output int lat);
    exp_t e;
    int p = -1;
    for (int i = 0; i < 8; i++) if (x[i] != y[i]) p = i;
    e.eq  = x == y;
    e.gt  = x > y;
    e.lt  = x < y;
    e.cyc = (j == 1 && p >= 0) ? 8 - p : 8;
    e.lat = e.cyc + 1;
    e.c0  = cyc;
    lat   = e.lat;
    if (j == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) if (rst_n) for (int j = 0; j < 2; j++) if (done[j]) begin
    exp_t e;
    if ((j == 0 ? q0.size() : q1.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_done u%0d: done=1 with no request outstanding", j);
    end else begin
      if (j == 0) e = q0.pop_front(); else e = q1.pop_front();
      chk($sformatf("eq u%0d", j), int'(eq[j]), int'(e.eq));
      chk($sformatf("gt u%0d", j), int'(gt[j]), int'(e.gt));
      chk($sformatf("lt u%0d", j), int'(lt[j]), int'(e.lt));
      chk($sformatf("cycles u%0d", j), int'(cy[j]), e.cyc);
      chk($sformatf("latency u%0d", j), cyc - e.c0, e.lat);
      chk($sformatf("busy_in_done u%0d", j), int'(busy[j]), 0);
    end
  end

  task automatic chk_rst(string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s eq u%0d", tag, j), int'(eq[j]), 1);
      chk($sformatf("%s gt u%0d", tag, j), int'(gt[j]), 0);
      chk($sformatf("%s lt u%0d", tag, j), int'(lt[j]), 0);
      chk($sformatf("%s busy u%0d", tag, j), int'(busy[j]), 0);
      chk($sformatf("%s done u%0d", tag, j), int'(done[j]), 0);
      chk($sformatf("%s cycles u%0d", tag, j), int'(cy[j]), 0);
    end
  endtask

  task automatic wait_empty(int j);
    int n = 0;
    while ((j == 0 ? q0.size() : q1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL timeout u%0d: %0d results still outstanding, required 0", j, j == 0 ? q0.size() : q1.size());
      if (j == 0) q0.delete(); else q1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // single start pulse; operands scrambled one cycle later; optional stray start while busy
  task automatic pulse(int j, logic [7:0] x, logic [7:0] y, bit stray);
    int lat;
    @(negedge clk);
    a[j] = x;
    b[j] = y;
    start[j] = 1'b1;
    push(j, x, y, lat);
    @(negedge clk);
    start[j] = 1'b0;
    a[j] = ~x;
    b[j] = ~y;
    if (stray) begin
      repeat (2) @(negedge clk);
      start[j] = 1'b1;
      @(negedge clk);
      start[j] = 1'b0;
    end
    wait_empty(j);
  endtask

  // start held high: the next request is accepted exactly latency+1 cycles after the previous
  task automatic drive(int j, int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start[j] = 1'b1;
      push(j, a[j], b[j], lat);
      @(posedge clk);
      #1;
      a[j] = 8'($urandom);
      case ($urandom_range(3))
        0: b[j] = a[j];
        1: b[j] = a[j] ^ (8'd1 << $urandom_range(7));
        default: b[j] = 8'($urandom);
      endcase
      repeat (lat) @(posedge clk);
    end
    @(negedge clk);
    start[j] = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 2; j++) begin
      a[j] = '0;
      b[j] = '0;
    end
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    pulse(1, 8'h80, 8'h7F, 1'b0);
    pulse(1, 8'h12, 8'h13, 1'b1);
    pulse(1, 8'hA5, 8'hA5, 1'b0);
    pulse(0, 8'hF0, 8'h0F, 1'b0);
    pulse(0, 8'h12, 8'h13, 1'b1);
    pulse(1, 8'h80, 8'h7F, 1'b0);
    @(negedge clk);
    a[1] = 8'h12;
    b[1] = 8'h13;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_rst("midrun_reset");
    repeat (12) @(negedge clk);
    a[0] = 8'($urandom);
    b[0] = 8'($urandom);
    a[1] = 8'($urandom);
    b[1] = a[1] ^ 8'h01;
    fork
      drive(0, 1000);
      drive(1, 1000);
    join
    wait_empty(0);
    wait_empty(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
